// File: rtl/shl_arbiter.sv
// Two-requester round-robin arbiter in front of a shared left shifter.
// One-entry registered result slot with valid/ready backpressure.
module shl_arbiter #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [DATAWIDTH-1:0] req0_sh,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [DATAWIDTH-1:0] req1_sh,
  output logic                 req1_ready,
  output logic                 res_valid,
  output logic [DATAWIDTH-1:0] res_d,
  output logic                 res_id,
  input  logic                 res_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  slot_t state;
  slot_t state_nxt;

  logic                 last_grant;
  logic                 gnt_vld;
  logic                 gnt_id;
  logic                 slot_free;
  logic                 accept;
  logic [DATAWIDTH-1:0] sel_a;
  logic [DATAWIDTH-1:0] sel_sh;
  logic [DATAWIDTH-1:0] shl_d;

  assign slot_free = (state == EMPTY) || res_ready;

  // Grant is held off during reset so ready drops asynchronously.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        (req0_valid && req1_valid): begin
          gnt_vld = 1'b1;
          gnt_id  = ~last_grant;
        end
        (req0_valid && !req1_valid): begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end
        (!req0_valid && req1_valid): begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
        default: begin
          gnt_vld = 1'b0;
          gnt_id  = 1'b0;
        end
      endcase
    end
  end

  assign accept     = gnt_vld && slot_free;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  assign sel_a  = gnt_id ? req1_a  : req0_a;
  assign sel_sh = gnt_id ? req1_sh : req0_sh;

  always_comb begin
    shl_d = '0;
    if (int'(sel_sh) < DATAWIDTH) begin
      shl_d = sel_a << sel_sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      accept:                 state_nxt = FULL;
      (!accept && res_ready): state_nxt = EMPTY;
      default:                state_nxt = state;
    endcase
  end

  always_comb begin
    res_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_d      <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      res_d      <= shl_d;
      res_id     <= gnt_id;
      last_grant <= gnt_id;
    end
  end

endmodule

// File: tb/tb_shl_arbiter.sv
// Scoreboard bench for shl_arbiter: stimulus pushes expected
// results, a negedge monitor pops them on each consumed output.
module tb_shl_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic [7:0] req0_a;
  logic [7:0] req0_sh;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_a;
  logic [7:0] req1_sh;
  logic       req1_ready;
  logic       res_valid;
  logic [7:0] res_d;
  logic       res_id;
  logic       res_ready;

  int checks;
  int failures;

  logic [8:0] exp_q[$];

  shl_arbiter #(.DATAWIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_sh    (req0_sh),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_sh    (req1_sh),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_d      (res_d),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed when valid and ready are both high.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got id=%0d d=%0h expected none",
                 res_id, res_d);
      end else begin
        e = exp_q.pop_front();
        chk("res_id", int'(res_id), int'(e[8]));
        chk("res_d", int'(res_d), int'(e[7:0]));
      end
    end
  end

  // Called just after a posedge; checks readies at the negedge and
  // leaves the bench just after the following posedge.
  task automatic step(
    input logic       v0,
    input logic [7:0] a0,
    input logic [7:0] s0,
    input logic       v1,
    input logic [7:0] a1,
    input logic [7:0] s1,
    input logic       rr,
    input logic       er0,
    input logic       er1,
    input logic [7:0] ed
  );
    req0_valid = v0;
    req0_a     = a0;
    req0_sh    = s0;
    req1_valid = v1;
    req1_a     = a1;
    req1_sh    = s1;
    res_ready  = rr;
    @(negedge clk);
    chk("req0_ready", int'(req0_ready), int'(er0));
    chk("req1_ready", int'(req1_ready), int'(er1));
    if (er0 || er1) begin
      exp_q.push_back({er1, ed});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, rr, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req0_a     = 8'h03;
    req0_sh    = 8'h02;
    req1_valid = 1'b0;
    req1_a     = 8'h00;
    req1_sh    = 8'h00;
    res_ready  = 1'b1;

    @(negedge clk);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_d", int'(res_d), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_req0_ready", int'(req0_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request after reset
    step(1, 8'h03, 8'd2, 0, 8'h00, 8'd0, 1, 1, 0, 8'h0C);
    idle(1);

    // Contention from fresh reset: 0,1,0,1
    do_reset();
    step(1, 8'h01, 8'd1, 1, 8'h01, 8'd7, 1, 1, 0, 8'h02);
    step(1, 8'h01, 8'd1, 1, 8'h01, 8'd7, 1, 0, 1, 8'h80);
    step(1, 8'h01, 8'd1, 1, 8'h01, 8'd7, 1, 1, 0, 8'h02);
    step(1, 8'h01, 8'd1, 1, 8'h01, 8'd7, 1, 0, 1, 8'h80);

    // Backpressure: slot holds 0A while req1 waits
    step(1, 8'h05, 8'd1, 0, 8'h00, 8'd0, 1, 1, 0, 8'h0A);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 8'd0, 1, 8'h11, 8'd4, 0, 0, 0, 8'h00);
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_res_d", int'(res_d), 8'h0A);
      chk("bp_res_id", int'(res_id), 0);
    end
    step(0, 8'h00, 8'd0, 1, 8'h11, 8'd4, 1, 0, 1, 8'h10);
    chk("nobubble_valid", int'(res_valid), 1);
    idle(1);

    // Shift boundaries
    step(1, 8'hFF, 8'd0, 0, 8'h00, 8'd0, 1, 1, 0, 8'hFF);
    step(1, 8'hFF, 8'd7, 0, 8'h00, 8'd0, 1, 1, 0, 8'h80);
    step(1, 8'hFF, 8'd8, 0, 8'h00, 8'd0, 1, 1, 0, 8'h00);
    step(1, 8'hFF, 8'hFF, 0, 8'h00, 8'd0, 1, 1, 0, 8'h00);
    idle(1);

    // Reset mid-operation with a held result
    step(1, 8'h01, 8'd3, 0, 8'h00, 8'd0, 1, 1, 0, 8'h08);
    idle(0);
    chk("held_valid", int'(res_valid), 1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", int'(res_valid), 0);
    chk("midrst_req0_ready", int'(req0_ready), 0);
    chk("midrst_req1_ready", int'(req1_ready), 0);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    step(1, 8'h02, 8'd1, 1, 8'h40, 8'd1, 1, 1, 0, 8'h04);
    step(1, 8'h02, 8'd1, 1, 8'h40, 8'd1, 1, 0, 1, 8'h80);

    // Idle requester 0, then fairness at contention
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 8'd0, 1, 8'h03, 8'd1, 1, 0, 1, 8'h06);
    end
    step(1, 8'h81, 8'd1, 1, 8'h03, 8'd1, 1, 1, 0, 8'h02);
    step(1, 8'h81, 8'd1, 1, 8'h03, 8'd1, 1, 0, 1, 8'h06);

    for (int i = 0; i < 3; i++) begin
      idle(1);
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("final_res_valid", int'(res_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
